// File: rtl/cgol_pkg.sv
// cgol_pkg: shared state encoding and geometry constants for the Game of Life core
package cgol_pkg;
    localparam int CGOL_WIDTH   = 8;
    localparam int CGOL_ROWS    = 8;
    localparam int CGOL_REGBITS = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        RECV       = 3'd2,
        COMMIT     = 3'd3,
        DONE       = 3'd4
    } loader_state_t;
endpackage

// File: rtl/cgol_flops.sv
// cgol_flops: two-phase flop primitives (master samples on ph2, slave shows on ph1)
module flopen #(
    parameter int W = 1
) (
    input  logic         ph1,
    input  logic         ph2,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] master;

    // master captures d when enabled
    always_ff @(posedge ph2) master <= en ? d : master;

    // slave makes the captured value visible
    always_ff @(posedge ph1) q <= master;
endmodule

module flopenr #(
    parameter int W = 1
) (
    input  logic         ph1,
    input  logic         ph2,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] master;

    // master captures d when enabled; active-low reset clears it synchronously
    always_ff @(posedge ph2) master <= !reset ? '0 : en ? d : master;

    // slave makes the captured value visible
    always_ff @(posedge ph1) q <= master;
endmodule

// File: rtl/cgol_pattern_loader_row_buffer.sv
// loader_row_buffer: ROWS x WIDTH pattern staging array, one write port, async read
module loader_row_buffer
    import cgol_pkg::*;
#(
    parameter int WIDTH   = CGOL_WIDTH,
    parameter int ROWS    = CGOL_ROWS,
    parameter int REGBITS = CGOL_REGBITS
) (
    input  logic               ph1,
    input  logic               ph2,
    input  logic               we,
    input  logic [REGBITS-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [REGBITS-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] mem [ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        flopen #(.W(WIDTH)) u_row (
            .ph1(ph1),
            .ph2(ph2),
            .en(we && waddr == REGBITS'(r)),
            .d(wdata),
            .q(mem[r])
        );
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/cgol_pattern_loader.sv
// cgol_pattern_loader: buffers an 8-row seed pattern and commits it in one frame-aligned burst
module cgol_pattern_loader
    import cgol_pkg::*;
#(
    parameter int WIDTH   = CGOL_WIDTH,
    parameter int ROWS    = CGOL_ROWS,
    parameter int REGBITS = CGOL_REGBITS,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic               ph1,
    input  logic               ph2,
    input  logic               reset,
    input  logic               load_start,
    input  logic               frame_sync,
    input  logic               byte_valid,
    input  logic [WIDTH-1:0]   byte_data,
    output logic               byte_ready,
    output logic               hold,
    output logic               wr_en,
    output logic [REGBITS-1:0] wr_addr,
    output logic [WIDTH-1:0]   wr_data,
    output logic               load_done,
    output logic               err
);
    localparam logic [REGBITS-1:0] LAST   = REGBITS'(ROWS - 1);
    localparam logic [TO_W-1:0]    TO_MAX = TO_W'(TIMEOUT);
    localparam int                 OW     = 4 + REGBITS + WIDTH;

    loader_state_t      state, state_next;
    logic [2:0]         state_q;
    logic [REGBITS-1:0] ptr, ptr_next;
    logic [TO_W-1:0]    cnt, cnt_next;
    logic               err_next, xfer, timeout;
    logic [WIDTH-1:0]   rd_data;
    logic               byte_ready_next, hold_next, wr_en_next, load_done_next;
    logic [REGBITS-1:0] wr_addr_next;
    logic [WIDTH-1:0]   wr_data_next;

    assign state   = loader_state_t'(state_q);
    assign xfer    = state == RECV && byte_valid;
    assign timeout = state == RECV && !byte_valid && cnt == TO_MAX;

    flopenr #(.W(3)) u_state (
        .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(state_next), .q(state_q)
    );

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = load_start ? WAIT_FRAME : IDLE;
            WAIT_FRAME: state_next = frame_sync ? RECV : WAIT_FRAME;
            RECV:       state_next = (xfer && ptr == LAST) ? COMMIT : timeout ? IDLE : RECV;
            COMMIT:     state_next = ptr == LAST ? DONE : COMMIT;
            default:    state_next = IDLE;
        endcase
    end

    // pointer wraps naturally; timeout counter saturates and only runs in RECV
    always_comb begin
        ptr_next = state == WAIT_FRAME ? '0 : (xfer || state == COMMIT) ? ptr + 1'b1 : ptr;
        cnt_next = (state != RECV || xfer) ? '0 : cnt == TO_MAX ? cnt : cnt + 1'b1;
        err_next = (state == IDLE && load_start) ? 1'b0 : timeout ? 1'b1 : err;
    end

    flopenr #(.W(REGBITS)) u_ptr (
        .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(ptr_next), .q(ptr)
    );
    flopenr #(.W(TO_W)) u_cnt (
        .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(cnt_next), .q(cnt)
    );
    flopenr #(.W(1)) u_err (
        .ph1(ph1), .ph2(ph2), .reset(reset), .en(1'b1), .d(err_next), .q(err)
    );

    loader_row_buffer #(.WIDTH(WIDTH), .ROWS(ROWS), .REGBITS(REGBITS)) u_buf (
        .ph1(ph1),
        .ph2(ph2),
        .we(xfer),
        .waddr(ptr),
        .wdata(byte_data),
        .raddr(ptr_next),
        .rdata(rd_data)
    );

    // outputs are decoded from the upcoming state so they appear registered with it
    always_comb begin
        byte_ready_next = state_next == RECV;
        hold_next       = state_next != IDLE;
        wr_en_next      = state_next == COMMIT;
        wr_addr_next    = wr_en_next ? ptr_next : '0;
        wr_data_next    = wr_en_next ? rd_data : '0;
        load_done_next  = state_next == DONE;
    end

    flopenr #(.W(OW)) u_out (
        .ph1(ph1),
        .ph2(ph2),
        .reset(reset),
        .en(1'b1),
        .d({byte_ready_next, hold_next, wr_en_next, wr_addr_next, wr_data_next, load_done_next}),
        .q({byte_ready, hold, wr_en, wr_addr, wr_data, load_done})
    );
endmodule

// File: tb/tb_cgol_pattern_loader.sv
// tb_cgol_pattern_loader: directed self-checking bench for the pattern loader
module tb_cgol_pattern_loader;
    logic       ph1 = 1'b0, ph2 = 1'b0;
    logic       reset, load_start, frame_sync, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, hold, wr_en, load_done, err;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int failures = 0;
    int nwr = 0;
    int base;
    logic [7:0] rf [8];
    logic [7:0] pat [8];

    cgol_pattern_loader dut (
        .ph1(ph1),
        .ph2(ph2),
        .reset(reset),
        .load_start(load_start),
        .frame_sync(frame_sync),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .hold(hold),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .load_done(load_done),
        .err(err)
    );

    initial forever begin
        #5 ph1 = 1'b1;
        #5 ph1 = 1'b0;
        #5 ph2 = 1'b1;
        #5 ph2 = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ph1);
        #1;
        if (wr_en === 1'b1) begin
            rf[wr_addr] = wr_data;
            nwr++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, byte_ready, 0);
        chk({tag, "_hold"}, hold, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_done"}, load_done, 0);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("start_hold", hold, 1);
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("start_ready", byte_ready, 1);
    endtask

    task automatic commit_check(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_wr_en"}, wr_en, 1);
            chk({tag, "_wr_addr"}, wr_addr, i);
            chk({tag, "_wr_data"}, wr_data, pat[i]);
            chk({tag, "_hold"}, hold, 1);
            if (i == 3) begin
                load_start = 1'b1;
                frame_sync = 1'b1;
            end
            step();
            load_start = 1'b0;
            frame_sync = 1'b0;
            byte_valid = 1'b0;
        end
        chk({tag, "_done"}, load_done, 1);
        chk({tag, "_done_hold"}, hold, 1);
        chk({tag, "_done_wr_en"}, wr_en, 0);
        step();
        chk({tag, "_end_hold"}, hold, 0);
        chk({tag, "_end_done"}, load_done, 0);
        chk({tag, "_end_err"}, err, 0);
    endtask

    initial begin
        int gaps [8];
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        reset = 1'b0;
        load_start = 1'b0;
        frame_sync = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        step();
        step();
        reset = 1'b1;
        chk_idle("reset");
        chk("reset_err", err, 0);

        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk_idle("fs_idle");

        // glider, back-to-back bytes, with stray load_start/frame_sync pulses
        pat = '{8'h18, 8'h30, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        base = nwr;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("g_hold", hold, 1);
        chk("g_wait_ready", byte_ready, 0);
        step();
        chk("g_wait_hold", hold, 1);
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1;
            byte_data = pat[i];
            chk("g_ready", byte_ready, 1);
            if (i == 2) begin
                load_start = 1'b1;
                frame_sync = 1'b1;
            end
            step();
            load_start = 1'b0;
            frame_sync = 1'b0;
        end
        byte_data = 8'hAA;
        chk("g_ready_after8", byte_ready, 0);
        commit_check("glider");
        chk("g_writes", nwr - base, 8);

        // bytes with gaps; an extra byte offered after the 8th is refused
        pat = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hFF, 8'h00, 8'h5A, 8'hC3};
        gaps = '{0, 3, 20, 1, 7, 0, 12, 5};
        base = nwr;
        start_load();
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b0;
            byte_data = 8'h77;
            for (int g = 0; g < gaps[i]; g++) begin
                chk("gap_ready", byte_ready, 1);
                step();
            end
            byte_valid = 1'b1;
            byte_data = pat[i];
            chk("gap_ready_xfer", byte_ready, 1);
            step();
        end
        byte_data = 8'hEE;
        chk("gap_ready_after8", byte_ready, 0);
        commit_check("gaps");
        chk("gap_writes", nwr - base, 8);
        for (int i = 0; i < 8; i++) chk("gap_rf", rf[i], pat[i]);

        // timeout after 3 bytes: no writes, err set, hold dropped together
        base = nwr;
        start_load();
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_data = 8'h11;
            step();
        end
        byte_valid = 1'b0;
        for (int k = 0; k < 256; k++) begin
            chk("to_hold", hold, 1);
            chk("to_err_low", err, 0);
            step();
        end
        chk("to_err", err, 1);
        chk("to_hold_low", hold, 0);
        chk("to_ready_low", byte_ready, 0);
        chk("to_writes", nwr - base, 0);
        step();
        chk("to_err_sticky", err, 1);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("to_err_clear", err, 0);
        chk("to_new_hold", hold, 1);

        // waiting for frame_sync never times out
        for (int k = 0; k < 100; k++) begin
            chk("wf_hold", hold, 1);
            chk("wf_ready", byte_ready, 0);
            chk("wf_err", err, 0);
            step();
        end

        // reset mid-RECV after 5 bytes
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            byte_valid = 1'b1;
            byte_data = 8'h99;
            step();
        end
        byte_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_idle("rst_recv");
        chk("rst_recv_err", err, 0);
        step();
        chk("rst_recv_stay", hold, 0);
        chk("rst_recv_writes", nwr - base, 0);

        // reset mid-COMMIT after row 3: rows 0-3 new, rows 4-7 keep the previous load
        pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        start_load();
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1;
            byte_data = pat[i];
            step();
        end
        byte_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rc_wr_addr", wr_addr, i);
            if (i == 3) reset = 1'b0;
            step();
        end
        reset = 1'b1;
        chk_idle("rst_commit");
        for (int k = 0; k < 4; k++) begin
            chk("rc_quiet", wr_en, 0);
            step();
        end
        chk("rc_writes", nwr - base, 4);
        chk("rc_rf0", rf[0], 8'h01);
        chk("rc_rf3", rf[3], 8'h08);
        chk("rc_rf4", rf[4], 8'hFF);
        chk("rc_rf7", rf[7], 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
